// File: rtl/data_mem_hs_if.sv
// ----------------------------------------------------------------------------
// data_mem_hs_if
//   Request/response handshake bundle for the data_mem_hs data memory.
//   Signals:
//     ReqValid   requester -> memory  request present
//     ReqReady   memory -> requester  memory can accept a request
//     Addr       requester -> memory  byte address (AW bits)
//     Size       requester -> memory  00 byte, 01 halfword, 1x word
//     LoadSigned requester -> memory  sign-extend sub-word loads
//     WEN        requester -> memory  active-low write enable (0 = store)
//     DataIn     requester -> memory  store data, LSB-aligned
//     RespValid  memory -> requester  response present
//     RespReady  requester -> memory  requester takes the response
//     DataOut    memory -> requester  extended load data, 0 for stores/errors
//     Err        memory -> requester  misaligned or out-of-range access
// ----------------------------------------------------------------------------
interface data_mem_hs_if #(
    parameter int AW = 32
);
    logic          ReqValid;
    logic          ReqReady;
    logic [AW-1:0] Addr;
    logic [1:0]    Size;
    logic          LoadSigned;
    logic          WEN;
    logic [31:0]   DataIn;
    logic          RespValid;
    logic          RespReady;
    logic [31:0]   DataOut;
    logic          Err;

    modport master (
        output ReqValid, Addr, Size, LoadSigned, WEN, DataIn, RespReady,
        input  ReqReady, RespValid, DataOut, Err
    );

    modport slave (
        input  ReqValid, Addr, Size, LoadSigned, WEN, DataIn, RespReady,
        output ReqReady, RespValid, DataOut, Err
    );
endinterface

// File: rtl/data_mem_hs.sv
// ----------------------------------------------------------------------------
// data_mem_hs
//   Multi-cycle byte-addressed little-endian data memory with a valid/ready
//   request/response handshake. One transaction outstanding at a time.
//   A request is accepted in IDLE, waits LATENCY edges in total, and the
//   access (store commit or load capture) happens on the edge entering RESP.
//   All state changes on the falling edge of CLK.
//   Ports:
//     CLK  clock, falling-edge active
//     RST  asynchronous reset, active-low (storage contents are kept)
//     bus  data_mem_hs_if slave modport (request, response, error flag)
//   Parameters:
//     DEPTH    storage bytes, power of two, >= 4
//     LATENCY  edges from accept to RespValid, >= 1
//     AW       address width; set address bits at or above log2(DEPTH)
//              flag an out-of-range error
// ----------------------------------------------------------------------------
module data_mem_hs #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2,
    parameter int AW      = 32
) (
    input  logic          CLK,
    input  logic          RST,
    data_mem_hs_if.slave  bus
);

    localparam int AB = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     data_q, data_d;
    logic            err_q, err_d;

    // Request fields captured at accept.
    logic [AW-1:0]   addr_q;
    logic [1:0]      size_q;
    logic            sgn_q;
    logic            wen_q;
    logic [31:0]     din_q;

    // Request currently being serviced: the live inputs while IDLE (so a
    // LATENCY=1 access can happen on its own accept edge), the captured
    // copy afterwards.
    logic [AW-1:0]   cur_addr;
    logic [1:0]      cur_size;
    logic            cur_sgn;
    logic            cur_wen;
    logic [31:0]     cur_din;

    logic            accept;
    logic            enter_resp;
    logic            misaligned;
    logic            out_of_range;
    logic            acc_err;
    logic            mem_we;
    logic [AB-1:0]   idx, hidx, widx;
    logic [7:0]      rd_b;
    logic [15:0]     rd_h;
    logic [31:0]     rd_w;
    logic [31:0]     load_ext;

    logic [7:0]      mem_q [DEPTH];

    assign accept   = bus.ReqValid && (state_q == S_IDLE);

    assign cur_addr = (state_q == S_IDLE) ? bus.Addr       : addr_q;
    assign cur_size = (state_q == S_IDLE) ? bus.Size       : size_q;
    assign cur_sgn  = (state_q == S_IDLE) ? bus.LoadSigned : sgn_q;
    assign cur_wen  = (state_q == S_IDLE) ? bus.WEN        : wen_q;
    assign cur_din  = (state_q == S_IDLE) ? bus.DataIn     : din_q;

    // Error decode. Because aligned accesses below DEPTH can never straddle
    // the top of storage, the byte indices below never wrap.
    assign misaligned   = ((cur_size == 2'b01) && cur_addr[0]) ||
                          (cur_size[1] && (cur_addr[1:0] != 2'b00));
    assign out_of_range = |(cur_addr >> AB);
    assign acc_err      = misaligned || out_of_range;

    assign idx  = cur_addr[AB-1:0];
    assign hidx = {idx[AB-1:1], 1'b0};
    assign widx = {idx[AB-1:2], 2'b00};

    assign rd_b = mem_q[idx];
    assign rd_h = {mem_q[hidx | AB'(1)], mem_q[hidx]};
    assign rd_w = {mem_q[widx | AB'(3)], mem_q[widx | AB'(2)],
                   mem_q[widx | AB'(1)], mem_q[widx]};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        load_ext = rd_w;
        unique case (cur_size)
            2'b00:   load_ext = {{24{cur_sgn & rd_b[7]}}, rd_b};
            2'b01:   load_ext = {{16{cur_sgn & rd_h[15]}}, rd_h};
            default: load_ext = rd_w;
        endcase
    end

    // Next-state / output decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CW'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == CW'(1)) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                if (bus.RespReady) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Response payload is captured once on entry to RESP and then held.
        data_d = data_q;
        err_d  = err_q;
        if (enter_resp) begin
            err_d  = acc_err;
            data_d = (acc_err || !cur_wen) ? 32'h0 : load_ext;
        end
    end

    // Gated by RST so nothing is written while the block is held in reset.
    assign mem_we = enter_resp && !cur_wen && !acc_err && RST;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // NOTE: reset is asynchronous; outputs drop to reset values as soon as
    // RST falls, without waiting for a clock edge.
    always_ff @(negedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            sgn_q   <= 1'b0;
            wen_q   <= 1'b1;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
            if (accept) begin
                addr_q <= bus.Addr;
                size_q <= bus.Size;
                sgn_q  <= bus.LoadSigned;
                wen_q  <= bus.WEN;
                din_q  <= bus.DataIn;
            end
        end
    end

    // NOTE: storage has no reset so it maps onto plain RAM and keeps its
    // contents across RST; only the control path is reset.
    always_ff @(negedge CLK) begin
        if (mem_we) begin
            unique case (cur_size)
                2'b00: mem_q[idx] <= cur_din[7:0];
                2'b01: begin
                    mem_q[hidx]          <= cur_din[7:0];
                    mem_q[hidx | AB'(1)] <= cur_din[15:8];
                end
                default: begin
                    mem_q[widx]          <= cur_din[7:0];
                    mem_q[widx | AB'(1)] <= cur_din[15:8];
                    mem_q[widx | AB'(2)] <= cur_din[23:16];
                    mem_q[widx | AB'(3)] <= cur_din[31:24];
                end
            endcase
        end
    end

    assign bus.ReqReady  = (state_q == S_IDLE);
    assign bus.RespValid = (state_q == S_RESP);
    assign bus.DataOut   = data_q;
    assign bus.Err       = err_q;

endmodule
